// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM table map, control-byte opcodes, status layout
// and the prefetch state encoding.
package vdp_pkg;

    localparam int unsigned NAME_BASE    = 32'h0000;
    localparam int unsigned NAME_SIZE    = 32'h0400;
    localparam int unsigned PATTERN_BASE = 32'h0800;
    localparam int unsigned PATTERN_SIZE = 32'h0800;
    localparam int unsigned COLOUR_BASE  = 32'h2000;
    localparam int unsigned COLOUR_SIZE  = 32'h0400;
    localparam int          OFFSET_W     = 11;

    localparam logic [1:0] OP_REG_WRITE  = 2'b10;
    localparam logic [1:0] OP_WRITE_ADDR = 2'b01;
    localparam logic [1:0] OP_READ_ADDR  = 2'b00;

    localparam int STATUS_F_BIT    = 7;
    localparam int REG1_IRQ_EN_BIT = 5;

    typedef enum logic [1:0] {
        TBL_NAME    = 2'd0,
        TBL_PATTERN = 2'd1,
        TBL_COLOUR  = 2'd2,
        TBL_NONE    = 2'd3
    } tbl_e;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,
        PF_FETCH   = 2'd1,
        PF_CAPTURE = 2'd2
    } pf_state_e;

    // Unsigned wrap turns the two-sided range test into a single compare.
    function automatic logic in_table(input int unsigned a, input int unsigned base,
                                      input int unsigned size);
        return (a - base) < size;
    endfunction

endpackage

// File: rtl/vdp_vram_decode.sv
// Maps a unified VRAM address onto a table select, a RAM-local offset and a
// mapped flag; purely combinational so any VRAM client can share it.
module vdp_vram_decode
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [ADDR_W-1:0]   addr,
    output tbl_e                tbl_sel,
    output logic [OFFSET_W-1:0] ram_offset,
    output logic                mapped
);

    logic [31:0] addr_ext;
    assign addr_ext = 32'(addr);

    always_comb begin
        tbl_sel    = TBL_NONE;
        ram_offset = '0;
        mapped     = 1'b0;
        if (in_table(addr_ext, NAME_BASE, NAME_SIZE)) begin
            tbl_sel    = TBL_NAME;
            ram_offset = OFFSET_W'(addr_ext - NAME_BASE);
            mapped     = 1'b1;
        end else if (in_table(addr_ext, PATTERN_BASE, PATTERN_SIZE)) begin
            tbl_sel    = TBL_PATTERN;
            ram_offset = OFFSET_W'(addr_ext - PATTERN_BASE);
            mapped     = 1'b1;
        end else if (in_table(addr_ext, COLOUR_BASE, COLOUR_SIZE)) begin
            tbl_sel    = TBL_COLOUR;
            ram_offset = OFFSET_W'(addr_ext - COLOUR_BASE);
            mapped     = 1'b1;
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: decodes Z180 data/control accesses into VRAM writes,
// read-ahead fetches, register writes and status reads.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic                  pxclk,
    input  logic                  reset,
    input  logic                  cpu_wr_stb,
    input  logic                  cpu_rd_stb,
    input  logic                  cpu_mode,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    input  logic                  vsync_in,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_wdata,
    output logic                  name_we,
    output logic                  pattern_we,
    output logic                  colour_we,
    output logic                  vram_re,
    input  logic [7:0]            name_rdata,
    input  logic [7:0]            pattern_rdata,
    input  logic [7:0]            colour_rdata,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  irq
);

    // Strobes are single-cycle pulses with no ready/backpressure: the CPU
    // guarantees at least 4 cycles between strobes, so every access completes
    // (including the two-cycle prefetch) before the next one can arrive.

    pf_state_e                 state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W-1:0]         vram_addr_q, vram_addr_d;
    logic [7:0]                vram_wdata_q, vram_wdata_d;
    logic [7:0]                latch_q, latch_d;
    logic [7:0]                buf_q, buf_d;
    logic [7:0]                rdata_q, rdata_d;
    logic [NUM_REGS-1:0][7:0]  regs_q, regs_d;
    logic                      second_q, second_d;
    logic                      f_q, f_d;
    logic                      vsync_prev_q, vsync_prev_d;
    logic                      wr_q, wr_d;
    logic                      start_fetch;
    logic                      f_clear;
    logic [2:0]                reg_idx;

    tbl_e                      dec_sel;
    logic [OFFSET_W-1:0]       dec_offset;
    logic                      dec_mapped;
    logic                      unused_offset;

    // The registered access address drives both write-enable decode and capture.
    vdp_vram_decode #(.ADDR_W(ADDR_W)) u_decode (
        .addr       (vram_addr_q),
        .tbl_sel    (dec_sel),
        .ram_offset (dec_offset),
        .mapped     (dec_mapped)
    );

    assign unused_offset = ^dec_offset;
    assign reg_idx       = cpu_wdata[2:0];

    always_comb begin
        addr_d       = addr_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        latch_d      = latch_q;
        buf_d        = buf_q;
        rdata_d      = rdata_q;
        regs_d       = regs_q;
        second_d     = second_q;
        wr_d         = 1'b0;
        start_fetch  = 1'b0;
        f_clear      = 1'b0;
        state_d      = state_q;
        vsync_prev_d = vsync_in;

        if (cpu_wr_stb) begin
            if (cpu_mode) begin
                if (!second_q) begin
                    latch_d  = cpu_wdata;
                    second_d = 1'b1;
                end else begin
                    second_d = 1'b0;
                    case (cpu_wdata[7:6])
                        OP_REG_WRITE: begin
                            if (32'(reg_idx) < NUM_REGS) regs_d[reg_idx] = latch_q;
                        end
                        OP_WRITE_ADDR: addr_d = ADDR_W'({cpu_wdata[5:0], latch_q});
                        OP_READ_ADDR: begin
                            vram_addr_d = ADDR_W'({cpu_wdata[5:0], latch_q});
                            addr_d      = ADDR_W'({cpu_wdata[5:0], latch_q}) + ADDR_W'(1);
                            start_fetch = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                vram_addr_d  = addr_q;
                vram_wdata_d = cpu_wdata;
                wr_d         = 1'b1;
                addr_d       = addr_q + ADDR_W'(1);
                second_d     = 1'b0;
            end
        end

        if (cpu_rd_stb) begin
            second_d = 1'b0;
            if (cpu_mode) begin
                rdata_d = '0;
                rdata_d[STATUS_F_BIT] = f_q;
                f_clear = 1'b1;
            end else begin
                rdata_d     = buf_q;
                vram_addr_d = addr_q;
                addr_d      = addr_q + ADDR_W'(1);
                start_fetch = 1'b1;
            end
        end

        // A vsync edge wins over a same-cycle status-read clear.
        f_d = f_q;
        if (vsync_in && !vsync_prev_q) f_d = 1'b1;
        else if (f_clear)              f_d = 1'b0;

        case (state_q)
            PF_IDLE:    if (start_fetch) state_d = PF_FETCH;
            PF_FETCH:   state_d = PF_CAPTURE;
            PF_CAPTURE: begin
                state_d = PF_IDLE;
                case (dec_sel)
                    TBL_NAME:    buf_d = name_rdata;
                    TBL_PATTERN: buf_d = pattern_rdata;
                    TBL_COLOUR:  buf_d = colour_rdata;
                    default:     buf_d = 8'hFF;
                endcase
            end
            default:    state_d = PF_IDLE;
        endcase
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            state_q      <= PF_IDLE;
            addr_q       <= '0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            latch_q      <= '0;
            buf_q        <= '0;
            rdata_q      <= '0;
            regs_q       <= '0;
            second_q     <= 1'b0;
            f_q          <= 1'b0;
            vsync_prev_q <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            latch_q      <= latch_d;
            buf_q        <= buf_d;
            rdata_q      <= rdata_d;
            regs_q       <= regs_d;
            second_q     <= second_d;
            f_q          <= f_d;
            vsync_prev_q <= vsync_prev_d;
            wr_q         <= wr_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign name_we    = wr_q && dec_mapped && (dec_sel == TBL_NAME);
    assign pattern_we = wr_q && dec_mapped && (dec_sel == TBL_PATTERN);
    assign colour_we  = wr_q && dec_mapped && (dec_sel == TBL_COLOUR);
    assign vram_re    = (state_q == PF_FETCH);
    assign regs_out   = regs_q;
    assign irq        = f_q & regs_q[1][REG1_IRQ_EN_BIT];

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed plus randomized bench for vdp_cpu_port against a unified-memory
// behavioural model of the VDP CPU port.
module tb_vdp_cpu_port;

  logic        pxclk;
  logic        reset;
  logic        cpu_wr_stb;
  logic        cpu_rd_stb;
  logic        cpu_mode;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        vsync_in;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        name_we;
  logic        pattern_we;
  logic        colour_we;
  logic        vram_re;
  logic [7:0]  name_rdata = '0;
  logic [7:0]  pattern_rdata = '0;
  logic [7:0]  colour_rdata = '0;
  logic [63:0] regs_out;
  logic        irq;

  vdp_cpu_port #(.ADDR_W(14), .NUM_REGS(8)) dut (
    .pxclk         (pxclk),
    .reset         (reset),
    .cpu_wr_stb    (cpu_wr_stb),
    .cpu_rd_stb    (cpu_rd_stb),
    .cpu_mode      (cpu_mode),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .vsync_in      (vsync_in),
    .vram_addr     (vram_addr),
    .vram_wdata    (vram_wdata),
    .name_we       (name_we),
    .pattern_we    (pattern_we),
    .colour_we     (colour_we),
    .vram_re       (vram_re),
    .name_rdata    (name_rdata),
    .pattern_rdata (pattern_rdata),
    .colour_rdata  (colour_rdata),
    .regs_out      (regs_out),
    .irq           (irq)
  );

  // ---------------- clock / reset ----------------
  initial pxclk = 1'b0;
  always #5 pxclk = ~pxclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- external table RAMs ----------------
  logic [7:0] name_ram    [1024];
  logic [7:0] pattern_ram [2048];
  logic [7:0] colour_ram  [1024];

  always @(posedge pxclk) begin
    if (name_we)    name_ram[vram_addr[9:0]]     <= vram_wdata;
    if (pattern_we) pattern_ram[vram_addr[10:0]] <= vram_wdata;
    if (colour_we)  colour_ram[vram_addr[9:0]]   <= vram_wdata;
    if (vram_re) begin
      name_rdata    <= name_ram[vram_addr[9:0]];
      pattern_rdata <= pattern_ram[vram_addr[10:0]];
      colour_rdata  <= colour_ram[vram_addr[9:0]];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [16384];
  logic [7:0]  m_regs [8];
  logic [13:0] m_addr;
  logic [7:0]  m_latch;
  logic [7:0]  m_buf;
  logic        m_second;
  logic        m_f;

  int n_pass = 0;
  int n_checks = 0;

  function automatic bit is_mapped(input logic [13:0] a);
    return (a < 14'h0400) || (a >= 14'h0800 && a < 14'h1000) ||
           (a >= 14'h2000 && a < 14'h2400);
  endfunction

  // one-hot {colour, pattern, name} expected for a write at a
  function automatic logic [2:0] we_of(input logic [13:0] a);
    if (a < 14'h0400) return 3'b001;
    if (a >= 14'h0800 && a < 14'h1000) return 3'b010;
    if (a >= 14'h2000 && a < 14'h2400) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [7:0] m_read(input logic [13:0] a);
    return is_mapped(a) ? m_mem[a] : 8'hFF;
  endfunction

  function automatic logic [63:0] m_regs_flat();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  task automatic poke(input logic [13:0] a, input logic [7:0] v);
    m_mem[a] = v;
    if (a < 14'h0400) name_ram[a[9:0]] = v;
    else if (a >= 14'h0800 && a < 14'h1000) pattern_ram[a - 14'h0800] = v;
    else if (a >= 14'h2000 && a < 14'h2400) colour_ram[a - 14'h2000] = v;
  endtask

  task automatic m_reset();
    m_addr = '0; m_latch = '0; m_buf = '0; m_second = 1'b0; m_f = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
  endtask

  function automatic logic [13:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 14'($urandom_range(0, 'h3FF));
      1:       return 14'('h0800 + $urandom_range(0, 'h7FF));
      2:       return 14'('h2000 + $urandom_range(0, 'h3FF));
      default: return 14'($urandom_range(0, 'h3FFF));
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic mode, input logic [7:0] d);
    logic [2:0]  exp_we;
    logic [13:0] exp_addr;
    logic        exp_fetch;
    exp_we = '0; exp_fetch = 1'b0; exp_addr = m_addr;
    if (mode) begin
      if (!m_second) begin
        m_latch = d; m_second = 1'b1;
      end else begin
        m_second = 1'b0;
        case (d[7:6])
          2'b10: m_regs[d[2:0]] = m_latch;
          2'b01: m_addr = {d[5:0], m_latch};
          2'b00: begin
            exp_addr = {d[5:0], m_latch};
            exp_fetch = 1'b1;
            m_buf = m_read(exp_addr);
            m_addr = exp_addr + 14'd1;
          end
          default: ;
        endcase
      end
    end else begin
      exp_we = we_of(m_addr);
      if (exp_we != 3'b000) m_mem[m_addr] = d;
      m_addr = m_addr + 14'd1;
      m_second = 1'b0;
    end
    @(negedge pxclk);
    cpu_wr_stb = 1'b1; cpu_mode = mode; cpu_wdata = d;
    @(posedge pxclk); #1 cpu_wr_stb = 1'b0;
    @(negedge pxclk);
    check("wr_we", {colour_we, pattern_we, name_we}, exp_we);
    check("wr_re", vram_re, exp_fetch);
    if (exp_we != 3'b000 || exp_fetch) check("wr_vram_addr", vram_addr, exp_addr);
    if (exp_we != 3'b000) check("wr_vram_wdata", vram_wdata, d);
    check("wr_regs", regs_out, m_regs_flat());
    @(negedge pxclk);
    check("wr_we_one_cycle", {colour_we, pattern_we, name_we}, 3'b000);
    check("wr_re_one_cycle", vram_re, 1'b0);
    @(negedge pxclk);
  endtask

  task automatic cpu_read(input logic mode, input logic vs);
    logic [7:0]  exp_data;
    logic [13:0] exp_addr;
    logic        exp_fetch;
    exp_fetch = 1'b0; exp_addr = m_addr;
    if (mode) begin
      exp_data = {m_f, 7'b0};
      m_f = 1'b0;
    end else begin
      exp_data = m_buf;
      exp_fetch = 1'b1;
      m_buf = m_read(m_addr);
      m_addr = m_addr + 14'd1;
    end
    m_second = 1'b0;
    if (vs) m_f = 1'b1;
    @(negedge pxclk);
    cpu_rd_stb = 1'b1; cpu_mode = mode;
    if (vs) vsync_in = 1'b1;
    @(posedge pxclk); #1 cpu_rd_stb = 1'b0;
    @(negedge pxclk);
    vsync_in = 1'b0;
    check(mode ? "status_rdata" : "data_rdata", cpu_rdata, exp_data);
    check("rd_re", vram_re, exp_fetch);
    if (exp_fetch) check("rd_fetch_addr", vram_addr, exp_addr);
    check("rd_irq", irq, m_f & m_regs[1][5]);
    @(negedge pxclk);
    check("rd_re_one_cycle", vram_re, 1'b0);
    @(negedge pxclk);
  endtask

  task automatic vsync_pulse();
    @(negedge pxclk) vsync_in = 1'b1;
    @(negedge pxclk) vsync_in = 1'b0;
    m_f = 1'b1;
    check("vsync_irq", irq, m_regs[1][5]);
    @(negedge pxclk);
  endtask

  task automatic set_addr(input logic [1:0] op, input logic [13:0] a);
    cpu_write(1'b1, a[7:0]);
    cpu_write(1'b1, {op, a[13:8]});
  endtask

  // ---------------- directed then randomized sequence ----------------
  initial begin
    cpu_wr_stb = 1'b0; cpu_rd_stb = 1'b0; cpu_mode = 1'b0; cpu_wdata = '0;
    vsync_in = 1'b0; reset = 1'b1;
    for (int a = 0; a < 16384; a++) poke(14'(a), 8'($urandom));
    m_reset();
    repeat (3) @(posedge pxclk);
    @(negedge pxclk);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_vram_addr", vram_addr, 14'h0000);
    check("rst_vram_wdata", vram_wdata, 8'h00);
    check("rst_we", {colour_we, pattern_we, name_we}, 3'b000);
    check("rst_re", vram_re, 1'b0);
    check("rst_regs", regs_out, 64'h0);
    check("rst_irq", irq, 1'b0);
    reset = 1'b0;

    // name-table writes from address 0
    cpu_write(1'b1, 8'h00); cpu_write(1'b1, 8'h40);
    cpu_write(1'b0, 8'hAA); cpu_write(1'b0, 8'h55);

    // register 7 write
    cpu_write(1'b1, 8'h0A); cpu_write(1'b1, 8'h87);
    check("reg7_value", regs_out[63:56], 8'h0A);

    // read-ahead from pattern table, then confirm address via a write
    poke(14'h0810, 8'h3C);
    cpu_write(1'b1, 8'h10); cpu_write(1'b1, 8'h08);
    cpu_read(1'b0, 1'b0);
    cpu_write(1'b0, 8'hC3);

    // address wrap: unmapped 0x3FFF dropped, then name 0x000
    set_addr(2'b01, 14'h3FFF);
    cpu_write(1'b0, 8'h11); cpu_write(1'b0, 8'h22);

    // status flag and irq
    cpu_write(1'b1, 8'h20); cpu_write(1'b1, 8'h81);
    vsync_pulse();
    cpu_read(1'b1, 1'b0);
    cpu_read(1'b1, 1'b0);
    // vsync edge coincident with status read
    cpu_read(1'b1, 1'b1);
    cpu_read(1'b1, 1'b0);

    // pending first byte discarded by a data read
    cpu_write(1'b1, 8'h55);
    cpu_read(1'b0, 1'b0);
    cpu_write(1'b1, 8'h00); cpu_write(1'b1, 8'h40);
    cpu_write(1'b0, 8'h77);

    // reset during FETCH: the aborted capture must not load the buffer
    poke(14'h0811, 8'hA5);
    set_addr(2'b00, 14'h0810);
    @(negedge pxclk);
    cpu_rd_stb = 1'b1; cpu_mode = 1'b0;
    @(posedge pxclk); #1 cpu_rd_stb = 1'b0; reset = 1'b1;
    @(negedge pxclk);
    check("abort_re_in_fetch", vram_re, 1'b1);
    @(posedge pxclk); #1 reset = 1'b0;
    m_reset();
    repeat (3) @(negedge pxclk);
    cpu_read(1'b0, 1'b0);

    // randomized operations
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: cpu_write(1'b1, 8'($urandom));
        1: set_addr(2'($urandom_range(0, 3)), rand_addr());
        2: cpu_write(1'b0, 8'($urandom));
        3: cpu_read(1'b0, 1'b0);
        4: cpu_read(1'b1, 1'($urandom_range(0, 1)));
        default: vsync_pulse();
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
